seq_recognizer: RTL and testbench
=================================

SEQ_RECOGNIZER -- requirements
Module: seq_recognizer

Interface
REQ-001 Parameter PAT_LEN, default 5, number of bits in the target pattern; legal range 2..16.
REQ-002 Parameter PATTERN, default 5'b10101, PAT_LEN-bit target pattern; bit PAT_LEN-1 is the first serial bit expected.
REQ-003 Parameter OVERLAP, default 1; 1 = overlapping matches allowed, 0 = search restarts from empty after each match.
REQ-004 Parameter CNT_W, default 8, width of the match counter.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  qualifies in; bit consumed only when high.
REQ-008 in  input  1  serial data bit.
REQ-009 clear  input  1  synchronous flush of match progress and counter.
REQ-010 out  output  1  registered one-cycle match pulse.
REQ-011 progress  output  5  registered count of pattern bits currently matched, 0..PAT_LEN-1.
REQ-012 match_cnt  output  CNT_W  registered saturating count of matches since reset/clear.

Function
REQ-013 Core SHALL be a Moore-style FSM with states S0..S(PAT_LEN-1), state index = matched-prefix length; progress reflects the state register.
REQ-014 On a clock edge with in_valid=1, next state SHALL be the longest prefix of PATTERN that is a suffix of (current matched prefix followed by in), i.e. KMP fallback, computed from parameters at elaboration.
REQ-015 When the consumed bit completes the full pattern, out SHALL be 1 in the following cycle, for exactly one cycle.
REQ-016 After a completed match with OVERLAP=1, next state SHALL be the longest proper prefix of PATTERN that is also its suffix; with OVERLAP=0, next state SHALL be S0.
REQ-017 With in_valid=0, state, match_cnt SHALL hold and out SHALL be 0 next cycle.
REQ-018 clear=1 SHALL force state S0, out 0 and match_cnt 0 on the next edge, with priority over in_valid/in.
REQ-019 Latency: bit sampled at edge N produces out=1 after edge N (visible cycle N+1); no additional pipeline.
REQ-020 Back-to-back matches (OVERLAP=1, self-overlapping pattern) SHALL produce out pulses on consecutive qualifying matches without dropped events.
REQ-021 match_cnt SHALL increment by 1 per match and saturate at 2^CNT_W-1 without wrap.
REQ-022 Pattern with no self-overlap SHALL behave identically for OVERLAP=0 and OVERLAP=1.

Reset
REQ-023 reset low SHALL immediately force state S0, out 0, progress 0, match_cnt 0, independent of clk.
REQ-024 Reset asserted mid-pattern SHALL discard partial progress; first bit after reset release starts from S0.
REQ-025 Outputs SHALL hold reset values until the first qualifying edge after reset deassertion.

Configuration
REQ-026 Macro SEQ_RECOGNIZER_CNT_EN defined: match counter implemented per REQ-021.
REQ-027 Macro undefined: counter logic absent, match_cnt port retained and driven constant 0; all other behaviour unchanged.

Verification (PAT_LEN=5, PATTERN=10101, macro defined unless noted)
REQ-028 reset low, stream 1,0,1,0,1 at in_valid=1 after release -> single out pulse the cycle after 5th bit; match_cnt=1; progress sequence 1,2,3,4,then 3 (OVERLAP=1).
REQ-029 OVERLAP=1, stream 1,0,1,0,1,0,1 -> out pulses after bits 5 and 7; match_cnt=2. OVERLAP=0 same stream -> one pulse; match_cnt=1.
REQ-030 Stream 1,0,1,0, in_valid low 3 cycles, then 1 -> progress holds 4 during gap, out pulse after final bit.
REQ-031 Stream 1,0,1,0, assert reset low asynchronously mid-cycle, release, then 1 -> no out pulse; progress=1.
REQ-032 Stream 1,0,1,0 then clear=1 with in=1,in_valid=1 same cycle -> no pulse, progress=0, match_cnt=0.
REQ-033 CNT_W=2, 4 overlapping matches -> match_cnt 1,2,3,3 (saturate); with macro undefined match_cnt stays 0 while out pulses unchanged.

Source files
------------

// File: rtl/seq_recognizer.sv
// Serial pattern recognizer: KMP-style Moore FSM that pulses `out` one cycle after
// the last bit of PATTERN is consumed. The state index equals the matched-prefix length.
// Optional match counter is built only when SEQ_RECOGNIZER_CNT_EN is defined;
// otherwise match_cnt is tied to zero.
module seq_recognizer #(
  parameter int unsigned        PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0] PATTERN = 5'b10101,
  parameter bit                 OVERLAP = 1'b1,
  parameter int unsigned        CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in,
  input  logic             clear,
  output logic             out,
  output logic [4:0]       progress,
  output logic [CNT_W-1:0] match_cnt
);

  // Only S0..S(PAT_LEN-1) are reachable; the full range keeps table indexing exact.
  typedef enum logic [3:0] {
    S0, S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, S12, S13, S14, S15
  } state_e;

  // Serial bit j of the pattern (j = 0 is the first bit expected).
  function automatic bit pat_bit(int unsigned j);
    logic [PAT_LEN-1:0] sh;
    sh = PATTERN >> (PAT_LEN - 1 - j);
    return sh[0];
  endfunction

  // Bit p of (matched prefix of length s) followed by b.
  function automatic bit str_bit(int unsigned s, bit b, int unsigned p);
    return (p < s) ? pat_bit(p) : b;
  endfunction

  // Longest pattern prefix that is a suffix of (prefix_s . b).
  function automatic int unsigned kmp_len(int unsigned s, bit b);
    int unsigned best;
    bit          ok;
    best = 0;
    for (int unsigned k = 1; k <= 16; k++) begin
      if (k <= s + 1) begin
        ok = 1'b1;
        for (int unsigned j = 0; j < 16; j++) begin
          if (j < k) begin
            if (str_bit(s, b, s + 1 - k + j) != pat_bit(j)) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  // Longest proper prefix of the pattern that is also its suffix.
  function automatic int unsigned border_len();
    int unsigned best;
    bit          ok;
    best = 0;
    for (int unsigned k = 1; k < 16; k++) begin
      if (k < PAT_LEN) begin
        ok = 1'b1;
        for (int unsigned j = 0; j < 16; j++) begin
          if (j < k) begin
            if (pat_bit(j) != pat_bit(PAT_LEN - k + j)) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  localparam int unsigned Border = border_len();
  localparam state_e      SWrap  = OVERLAP ? state_e'(4'(Border)) : S0;

  state_e nxt_tbl [16][2];
  logic   hit_tbl [16][2];

  // Transition and match tables, fully resolved at elaboration.
  for (genvar gs = 0; gs < 16; gs++) begin : g_state
    for (genvar gb = 0; gb < 2; gb++) begin : g_bit
      localparam int unsigned Len = (gs < PAT_LEN) ? kmp_len(gs, (gb != 0)) : 0;
      localparam bit          Hit = (gs < PAT_LEN) && (Len == PAT_LEN);
      assign hit_tbl[gs][gb] = Hit;
      assign nxt_tbl[gs][gb] = Hit ? SWrap : state_e'(4'(Len));
    end
  end

  state_e state_q, state_d;
  logic   out_q, out_d;

  // Next state and match pulse; clear overrides any consumed bit.
  always_comb begin
    state_d = state_q;
    out_d   = 1'b0;
    if (clear) begin
      state_d = S0;
    end else if (in_valid) begin
      state_d = nxt_tbl[state_q][in];
      out_d   = hit_tbl[state_q][in];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign out      = out_q;
  assign progress = {1'b0, state_q};

`ifdef SEQ_RECOGNIZER_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating match counter, flushed by clear.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (out_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_recognizer.sv
// Randomized self-checking bench for seq_recognizer with a history-based reference model.
module tb_seq_recognizer;

  localparam int NI = 4;
`ifdef SEQ_RECOGNIZER_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic in = 1'b0;
  logic clear = 1'b0;

  logic       out0, out1, out2, out3;
  logic [4:0] prog0, prog1, prog2, prog3;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic [3:0] cnt3;

  always #5 clk = ~clk;

  seq_recognizer u_ovl (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in), .clear(clear),
    .out(out0), .progress(prog0), .match_cnt(cnt0)
  );
  seq_recognizer #(.OVERLAP(1'b0)) u_novl (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in), .clear(clear),
    .out(out1), .progress(prog1), .match_cnt(cnt1)
  );
  seq_recognizer #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in), .clear(clear),
    .out(out2), .progress(prog2), .match_cnt(cnt2)
  );
  seq_recognizer #(.PAT_LEN(4), .PATTERN(4'b1100), .CNT_W(4)) u_p4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in), .clear(clear),
    .out(out3), .progress(prog3), .match_cnt(cnt3)
  );

  int out_w [NI];
  int prog_w [NI];
  int cnt_w [NI];
  assign out_w[0] = int'(out0);
  assign out_w[1] = int'(out1);
  assign out_w[2] = int'(out2);
  assign out_w[3] = int'(out3);
  assign prog_w[0] = int'(prog0);
  assign prog_w[1] = int'(prog1);
  assign prog_w[2] = int'(prog2);
  assign prog_w[3] = int'(prog3);
  assign cnt_w[0] = int'(cnt0);
  assign cnt_w[1] = int'(cnt1);
  assign cnt_w[2] = int'(cnt2);
  assign cnt_w[3] = int'(cnt3);

  // Per-instance configuration seen by the model.
  int pat_len [NI] = '{5, 5, 5, 4};
  int pat_val [NI] = '{'h15, 'h15, 'h15, 'hC};
  bit ovl     [NI] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int cnt_max [NI] = '{255, 255, 3, 15};

  // Model state: bits consumed since the last restart point.
  bit hist [NI][$];
  int exp_cnt [NI];
  int exp_out [NI];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(string tag, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit pbit(int i, int j);
    return bit'((pat_val[i] >> (pat_len[i] - 1 - j)) & 1);
  endfunction

  // True when the history ends with the whole pattern.
  function automatic bit model_hit(int i);
    int n = hist[i].size();
    int l = pat_len[i];
    if (n < l) return 1'b0;
    for (int j = 0; j < l; j++) if (hist[i][n - l + j] != pbit(i, j)) return 1'b0;
    return 1'b1;
  endfunction

  // Longest proper pattern prefix that ends the history.
  function automatic int model_prog(int i);
    int n = hist[i].size();
    for (int k = pat_len[i] - 1; k >= 1; k--) begin
      if (k <= n) begin
        bit ok = 1'b1;
        for (int j = 0; j < k; j++) if (hist[i][n - k + j] != pbit(i, j)) ok = 1'b0;
        if (ok) return k;
      end
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      hist[i].delete();
      exp_cnt[i] = 0;
      exp_out[i] = 0;
    end
  endtask

  task automatic model_step(bit v, bit b, bit c);
    for (int i = 0; i < NI; i++) begin
      exp_out[i] = 0;
      if (c) begin
        hist[i].delete();
        exp_cnt[i] = 0;
      end else if (v) begin
        hist[i].push_back(b);
        if (hist[i].size() > 32) void'(hist[i].pop_front());
        if (model_hit(i)) begin
          exp_out[i] = 1;
          if (exp_cnt[i] < cnt_max[i]) exp_cnt[i]++;
          if (!ovl[i]) hist[i].delete();
        end
      end
    end
  endtask

  task automatic check_all(string ctx);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("%s.out%0d", ctx, i), out_w[i], exp_out[i]);
      check_eq($sformatf("%s.prog%0d", ctx, i), prog_w[i], model_prog(i));
      check_eq($sformatf("%s.cnt%0d", ctx, i), cnt_w[i], CntEn ? exp_cnt[i] : 0);
    end
  endtask

  // Called just after a rising edge; drives, clocks, then checks 1 time unit later.
  task automatic cycle(bit v, bit b, bit c);
    in_valid = v;
    in = b;
    clear = c;
    @(posedge clk);
    model_step(v, b, c);
    #1;
    check_all("cyc");
  endtask

  task automatic send_bits(int val, int n);
    for (int j = n - 1; j >= 0; j--) cycle(1'b1, bit'((val >> j) & 1), 1'b0);
  endtask

  // Asynchronous reset pulse placed mid-cycle.
  task automatic async_reset();
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    #2;
    reset = 1'b1;
    #1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    #2;
    reset = 1'b1;
    #1;

    // Idle cycles after release leave reset values in place.
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    // Single match, overlap fallback to prefix 101.
    send_bits('b10101, 5);
    check_eq("r28_out", out_w[0], 1);
    check_eq("r28_prog", prog_w[0], 3);
    check_eq("r28_cnt", cnt_w[0], CntEn ? 1 : 0);
    cycle(1'b0, 1'b0, 1'b0);
    check_eq("r28_pulse_end", out_w[0], 0);

    // Overlapping vs restarting search.
    async_reset();
    send_bits('b1010101, 7);
    check_eq("r29_cnt_ovl", cnt_w[0], CntEn ? 2 : 0);
    check_eq("r29_cnt_novl", cnt_w[1], CntEn ? 1 : 0);
    check_eq("r29_out_novl", out_w[1], 0);

    // Gap in in_valid holds progress.
    async_reset();
    send_bits('b1010, 4);
    repeat (3) begin
      cycle(1'b0, 1'b1, 1'b0);
      check_eq("r30_hold", prog_w[0], 4);
    end
    cycle(1'b1, 1'b1, 1'b0);
    check_eq("r30_out", out_w[0], 1);

    // Reset mid-pattern discards progress.
    async_reset();
    send_bits('b1010, 4);
    async_reset();
    cycle(1'b1, 1'b1, 1'b0);
    check_eq("r31_out", out_w[0], 0);
    check_eq("r31_prog", prog_w[0], 1);

    // Clear wins over a completing bit.
    async_reset();
    send_bits('b1010, 4);
    cycle(1'b1, 1'b1, 1'b1);
    check_eq("r32_out", out_w[0], 0);
    check_eq("r32_prog", prog_w[0], 0);
    check_eq("r32_cnt", cnt_w[0], 0);

    // Saturation of a 2-bit counter over back-to-back matches.
    async_reset();
    send_bits('b1010101010101, 13);
    check_eq("r33_sat", cnt_w[2], CntEn ? 3 : 0);
    check_eq("r33_out", out_w[2], 1);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      bit v = ($urandom_range(0, 3) != 0);
      bit b = bit'($urandom_range(0, 1));
      bit c = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 149) == 0) async_reset();
      else cycle(v, b, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
